stream_framer: RTL and testbench
================================

// Module: stream_framer
// PURPOSE
//  Cuts a continuous I/Q sample stream into packets of exactly Length samples.
//  Marks each packet with SoP/EoP and feeds the Window stage directly.
//  Framing starts and stops on operator command, only on packet boundaries.
//  Full-rate valid/ready pipeline; a skid buffer keeps opInput_Ready registered.
// PARAMETERS
//  Width    16    sample width (signed two's complement), I and Q
//  Length   1024  samples per packet (>=1); must equal downstream window length
//  Complex  1     1: Q path live; 0: opOutput_Q tied to 0, Q logic removed
// PORTS
//  ipClk           in   1      clock
//  ipReset         in   1      reset: asynchronous assert, active-low
//  ipEnable        in   1      framing request (level)
//  ipInput_I       in   Width  input sample, I
//  ipInput_Q       in   Width  input sample, Q
//  ipInput_Valid   in   1      input sample valid
//  opInput_Ready   out  1      framer can accept (registered)
//  opOutput_SoP    out  1      first sample of packet
//  opOutput_EoP    out  1      last sample of packet
//  opOutput_I      out  Width  output sample, I
//  opOutput_Q      out  Width  output sample, Q (0 when Complex=0)
//  opOutput_Valid  out  1      output sample valid
//  ipOutput_Ready  in   1      downstream can accept
//  opFrameCount    out  16     completed packets since reset; wraps at 2^16
//  opBusy          out  1      1 while in FRAMING
// BEHAVIOUR
//  Reset (ipReset=0, async): all outputs 0, state IDLE, counter 0, skid empty.
//   opInput_Ready rises on the first clock edge after reset release.
//  Accept = ipInput_Valid & opInput_Ready; emit = opOutput_Valid & ipOutput_Ready.
//  Output register plus one skid register.
//   opInput_Ready <= skid empty after the edge.
//   An accept while the output register is stalled loads the skid register.
//   Skid drains into the output register on the next emit.
//  Latency: accepted sample appears on the output 1 cycle later when not stalled.
//   Throughput: 1 sample per cycle.
//  While Valid=1 and ipOutput_Ready=0, all opOutput_* are held stable.
//  Sample order is preserved; no sample is dropped in FRAMING.
//  FSM:
//   IDLE:
//    Accepted samples are discarded; opInput_Ready remains 1.
//    ipEnable=1 sampled at a clock edge -> FRAMING, counter=0.
//   FRAMING:
//    Every accepted sample is forwarded with SoP=(counter==0) and EoP=(counter==Length-1).
//    Counter increments per accept.
//    On the EoP accept: counter=0 and opFrameCount++.
//     If ipEnable=1, stay in FRAMING; the next accept carries SoP.
//     Otherwise -> IDLE.
//  ipEnable dropping mid-packet does not truncate: the packet completes to EoP.
//  An ipEnable pulse in IDLE with no input still starts framing (latched).
//  Length=1: every forwarded sample has SoP=EoP=1.
//  Counter width: max(1,$clog2(Length)); it never exceeds Length-1.
//  Simultaneous emit and accept with a full skid is impossible because Ready is 0.
//   With an empty skid, the accepted sample goes straight to the output register.
//  Async reset mid-packet: the partial packet is lost (Valid=0 immediately).
//   A new packet needs ipEnable again.
// TESTING
//  1. Length=4, Enable=1, Valid=1 always, Ready=1, I=0,1,2,...
//     -> SoP on I=0,4,8; EoP on I=3,7,11; opFrameCount=3 after 12 outputs.
//  2. Length=4, Ready low 3 cycles mid-packet
//     -> outputs held stable, opInput_Ready=0 once the skid is full.
//     After release: no sample lost or duplicated; sequence contiguous.
//  3. Length=8, Enable drops at sample 2 of a packet
//     -> samples 2..7 still emitted, EoP on 7, then IDLE.
//     Further inputs are consumed (Ready=1) and not emitted.
//  4. Length=1, Complex=0, Q=0x7FFF
//     -> every output has SoP=EoP=1 and opOutput_Q=0; count increments per sample.
//  5. Assert ipReset=0 at sample 5 of 8
//     -> Valid=0 and count=0 in the same cycle.
//     After release and re-enable, the first output carries SoP.
//  6. Random Valid/Ready (50%), Length=16, 1000 packets
//     -> scoreboard: order preserved, SoP/EoP every 16, opFrameCount=1000.

Source files
------------

// File: rtl/stream_framer.sv
// Cuts a continuous valid/ready I/Q stream into packets of exactly Length samples,
// marking SoP/EoP; framing starts and stops on operator command at packet boundaries.
module stream_framer #(
  parameter int Width   = 16,
  parameter int Length  = 1024,
  parameter int Complex = 1
) (
  input  logic             ipClk,
  input  logic             ipReset,
  input  logic             ipEnable,
  input  logic [Width-1:0] ipInput_I,
  input  logic [Width-1:0] ipInput_Q,
  input  logic             ipInput_Valid,
  output logic             opInput_Ready,
  output logic             opOutput_SoP,
  output logic             opOutput_EoP,
  output logic [Width-1:0] opOutput_I,
  output logic [Width-1:0] opOutput_Q,
  output logic             opOutput_Valid,
  input  logic             ipOutput_Ready,
  output logic [15:0]      opFrameCount,
  output logic             opBusy
);

  localparam int CountWidth = (Length > 1) ? $clog2(Length) : 1;
  localparam logic [CountWidth-1:0] LastCount = CountWidth'(Length - 1);

  typedef enum logic {
    StateIdle,
    StateFraming
  } stateT;

  stateT                 state;
  logic [CountWidth-1:0] sampleCount;

  logic             accept;
  logic             forward;
  logic             outFree;
  logic             inSoP;
  logic             inEoP;
  logic [Width-1:0] sampleQ;

  logic             skidValid;
  logic             skidSoP;
  logic             skidEoP;
  logic [Width-1:0] skidI;
  logic [Width-1:0] skidQ;

  // With Complex=0 the Q registers only ever see zero and collapse away.
  assign sampleQ = (Complex != 0) ? ipInput_Q : '0;

  always_comb begin
    accept  = ipInput_Valid & opInput_Ready;
    forward = accept & (state == StateFraming);
    outFree = ~opOutput_Valid | ipOutput_Ready;
    inSoP   = (sampleCount == '0);
    inEoP   = (sampleCount == LastCount);
  end

  assign opBusy = (state == StateFraming);

  // Framing control: a packet is never truncated, the stop request is only honoured at EoP.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state        <= StateIdle;
      sampleCount  <= '0;
      opFrameCount <= '0;
    end else begin
      case (state)
        StateIdle: begin
          if (ipEnable) begin
            state       <= StateFraming;
            sampleCount <= '0;
          end
        end
        StateFraming: begin
          if (accept) begin
            if (inEoP) begin
              sampleCount  <= '0;
              opFrameCount <= opFrameCount + 16'd1;
              if (!ipEnable) state <= StateIdle;
            end else begin
              sampleCount <= sampleCount + CountWidth'(1);
            end
          end
        end
        default: state <= StateIdle;
      endcase
    end
  end

  // Output register plus one skid slot; Ready is the registered "skid empty" flag,
  // so an accept can never arrive while the skid is still occupied.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      opOutput_Valid <= 1'b0;
      opOutput_SoP   <= 1'b0;
      opOutput_EoP   <= 1'b0;
      opOutput_I     <= '0;
      opOutput_Q     <= '0;
      skidValid      <= 1'b0;
      skidSoP        <= 1'b0;
      skidEoP        <= 1'b0;
      skidI          <= '0;
      skidQ          <= '0;
      opInput_Ready  <= 1'b0;
    end else begin
      if (outFree) begin
        if (skidValid) begin
          opOutput_Valid <= 1'b1;
          opOutput_SoP   <= skidSoP;
          opOutput_EoP   <= skidEoP;
          opOutput_I     <= skidI;
          opOutput_Q     <= skidQ;
          skidValid      <= 1'b0;
        end else if (forward) begin
          opOutput_Valid <= 1'b1;
          opOutput_SoP   <= inSoP;
          opOutput_EoP   <= inEoP;
          opOutput_I     <= ipInput_I;
          opOutput_Q     <= sampleQ;
        end else begin
          opOutput_Valid <= 1'b0;
        end
        opInput_Ready <= 1'b1;
      end else begin
        if (forward) begin
          skidValid <= 1'b1;
          skidSoP   <= inSoP;
          skidEoP   <= inEoP;
          skidI     <= ipInput_I;
          skidQ     <= sampleQ;
        end
        opInput_Ready <= ~(skidValid | forward);
      end
    end
  end

endmodule

// File: tb/tb_stream_framer.sv
// Self-checking bench for stream_framer: directed scenarios on four differently
// parameterised instances plus a randomized run against a queue-based packet model.
module tb_stream_framer;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
    logic        sop;
    logic        eop;
  } sampleT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic        en;
  logic        vld;
  logic        oRdy;
  logic [15:0] inI;
  logic [15:0] inQ;
  logic [1:0]  sel;

  logic [3:0]       rdyA, sopA, eopA, valA, busyA;
  logic [3:0][15:0] iA, qA, fcA;

  logic        obsReady, obsSoP, obsEoP, obsValid, obsBusy;
  logic [15:0] obsI, obsQ, obsFc;

  int checks = 0;
  int passes = 0;

  // Instances: 0 -> Length 4, 1 -> Length 8, 2 -> Length 1 real-only, 3 -> Length 16.
  for (genvar g = 0; g < 4; g++) begin : gDut
    localparam int L = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 1 : 16;
    localparam int C = (g == 2) ? 0 : 1;
    stream_framer #(.Width(16), .Length(L), .Complex(C)) u (
      .ipClk(clk), .ipReset(rstN), .ipEnable(en),
      .ipInput_I(inI), .ipInput_Q(inQ), .ipInput_Valid(vld),
      .opInput_Ready(rdyA[g]), .opOutput_SoP(sopA[g]), .opOutput_EoP(eopA[g]),
      .opOutput_I(iA[g]), .opOutput_Q(qA[g]), .opOutput_Valid(valA[g]),
      .ipOutput_Ready(oRdy), .opFrameCount(fcA[g]), .opBusy(busyA[g])
    );
  end

  always_comb begin
    obsReady = rdyA[sel];
    obsSoP   = sopA[sel];
    obsEoP   = eopA[sel];
    obsValid = valA[sel];
    obsBusy  = busyA[sel];
    obsI     = iA[sel];
    obsQ     = qA[sel];
    obsFc    = fcA[sel];
  end

  // Reference model: expQ holds forwarded samples not yet emitted, in order.
  sampleT expQ[$];
  bit     mFraming;
  int     mPos;
  int     mFrames;
  int     mLen;
  bit     mCplx;

  task automatic clearModel();
    expQ.delete();
    mFraming = 0;
    mPos     = 0;
    mFrames  = 0;
  endtask

  task automatic selectDut(input logic [1:0] s);
    sel   = s;
    mLen  = (s == 2'd0) ? 4 : (s == 2'd1) ? 8 : (s == 2'd2) ? 1 : 16;
    mCplx = (s != 2'd2);
  endtask

  // One clock: inputs set at the falling edge are applied on the rising edge.
  task automatic tick();
    bit     acc;
    bit     emt;
    sampleT s;
    acc = vld && obsReady;
    emt = obsValid && oRdy;
    @(posedge clk);
    if (emt && expQ.size() > 0) void'(expQ.pop_front());
    if (mFraming && acc) begin
      s.i   = inI;
      s.q   = mCplx ? inQ : 16'h0;
      s.sop = (mPos == 0);
      s.eop = (mPos == mLen - 1);
      expQ.push_back(s);
      if (s.eop) begin
        mPos = 0;
        mFrames++;
        if (!en) mFraming = 0;
      end else begin
        mPos++;
      end
    end else if (!mFraming && en) begin
      mFraming = 1;
      mPos     = 0;
    end
    @(negedge clk);
  endtask

  task automatic resetDut();
    rstN = 1'b0;
    en   = 1'b0;
    vld  = 1'b0;
    oRdy = 1'b1;
    inI  = '0;
    inQ  = '0;
    @(negedge clk);
    @(negedge clk);
    clearModel();
    rstN = 1'b1;
  endtask

  task automatic startFraming();
    en  = 1'b1;
    vld = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    selectDut(2'd0);
    rstN = 1'b0; en = 1'b0; vld = 1'b1; oRdy = 1'b1; inI = 16'h1234; inQ = 16'h5678;
    repeat (2) @(negedge clk);
    checks++;
    if ({obsValid, obsReady, obsSoP, obsEoP, obsBusy} !== 5'b0)
      $display("FAIL reset_ctrl: got %b required 00000", {obsValid, obsReady, obsSoP, obsEoP, obsBusy});
    else passes++;
    checks++;
    if (obsI !== 16'h0 || obsQ !== 16'h0 || obsFc !== 16'h0)
      $display("FAIL reset_data: got I=%h Q=%h fc=%0d required 0 0 0", obsI, obsQ, obsFc);
    else passes++;
    rstN = 1'b1; vld = 1'b0;
    clearModel();
    checks++;
    if (obsReady !== 1'b0) $display("FAIL ready_before_edge: got %b required 0", obsReady);
    else passes++;
    tick();
    checks++;
    if (obsReady !== 1'b1 || obsBusy !== 1'b0)
      $display("FAIL ready_after_edge: got ready=%b busy=%b required 1 0", obsReady, obsBusy);
    else passes++;
  endtask

  task automatic test_basic();
    int nIn;
    int nEm;
    selectDut(2'd0);
    resetDut();
    startFraming();
    nIn = 0; nEm = 0; oRdy = 1'b1;
    for (int c = 0; c < 40 && nEm < 12; c++) begin
      vld = (nIn < 12);
      inI = nIn[15:0];
      inQ = ~nIn[15:0];
      if (obsValid) begin
        checks++;
        if (obsI !== nEm[15:0] || obsQ !== ~nEm[15:0] || obsSoP !== (nEm % 4 == 0) || obsEoP !== (nEm % 4 == 3))
          $display("FAIL basic_out: got I=%0d Q=%h sop=%b eop=%b required I=%0d sop=%b eop=%b",
                   obsI, obsQ, obsSoP, obsEoP, nEm, (nEm % 4 == 0), (nEm % 4 == 3));
        else passes++;
        nEm++;
      end
      if (vld && obsReady) nIn++;
      tick();
    end
    checks++;
    if (nEm != 12) $display("FAIL basic_count: got %0d outputs required 12", nEm);
    else passes++;
    checks++;
    if (obsFc !== 16'd3) $display("FAIL basic_frames: got %0d required 3", obsFc);
    else passes++;
  endtask

  task automatic test_stall();
    int     nIn;
    int     nEm;
    int     stallLeft;
    bit     stalled;
    bit     sawBlock;
    bit     prevHeld;
    sampleT snap;
    selectDut(2'd0);
    resetDut();
    startFraming();
    nIn = 0; nEm = 0; stallLeft = 0; stalled = 0; sawBlock = 0; prevHeld = 0; snap = '0;
    for (int c = 0; c < 60 && nEm < 8; c++) begin
      if (nEm == 2 && !stalled) begin
        stalled   = 1;
        stallLeft = 3;
      end
      oRdy = (stallLeft == 0);
      vld  = 1'b1;
      inI  = nIn[15:0];
      inQ  = 16'(nIn + 256);
      if (prevHeld) begin
        checks++;
        if ({obsI, obsQ, obsSoP, obsEoP, obsValid} !== {snap, 1'b1})
          $display("FAIL stall_hold: got I=%0d valid=%b required I=%0d held", obsI, obsValid, snap.i);
        else passes++;
      end
      if (stallLeft > 0 && !obsReady) sawBlock = 1;
      if (obsValid && oRdy) begin
        checks++;
        if (obsI !== nEm[15:0] || obsQ !== 16'(nEm + 256) || obsSoP !== (nEm % 4 == 0) || obsEoP !== (nEm % 4 == 3))
          $display("FAIL stall_seq: got I=%0d sop=%b eop=%b required I=%0d", obsI, obsSoP, obsEoP, nEm);
        else passes++;
        nEm++;
      end
      prevHeld = obsValid && !oRdy;
      snap     = {obsI, obsQ, obsSoP, obsEoP};
      if (vld && obsReady) nIn++;
      tick();
      if (stallLeft > 0) stallLeft--;
    end
    checks++;
    if (!sawBlock) $display("FAIL stall_ready_low: got ready never 0 required 0 with skid full");
    else passes++;
    checks++;
    if (nEm != 8) $display("FAIL stall_count: got %0d outputs required 8", nEm);
    else passes++;
  endtask

  task automatic test_enable_drop();
    int nIn;
    int nEm;
    bit rdyLow;
    selectDut(2'd1);
    resetDut();
    startFraming();
    nIn = 0; nEm = 0; rdyLow = 0; oRdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (nIn >= 2) en = 1'b0;
      vld = 1'b1;
      inI = nIn[15:0];
      inQ = 16'h0055;
      if (obsValid) begin
        checks++;
        if (obsI !== nEm[15:0] || obsSoP !== (nEm == 0) || obsEoP !== (nEm == 7))
          $display("FAIL drop_out: got I=%0d sop=%b eop=%b required I=%0d sop=%b eop=%b",
                   obsI, obsSoP, obsEoP, nEm, (nEm == 0), (nEm == 7));
        else passes++;
        nEm++;
      end
      if (!obsReady) rdyLow = 1;
      if (obsReady) nIn++;
      tick();
    end
    checks++;
    if (nEm != 8) $display("FAIL drop_count: got %0d outputs required 8", nEm);
    else passes++;
    checks++;
    if (rdyLow || nIn != 40) $display("FAIL drop_consume: got %0d accepted required 40", nIn);
    else passes++;
    checks++;
    if (obsBusy !== 1'b0 || obsFc !== 16'd1)
      $display("FAIL drop_idle: got busy=%b fc=%0d required 0 1", obsBusy, obsFc);
    else passes++;
  endtask

  task automatic test_length1();
    logic [15:0] sent[$];
    int          nAcc;
    int          nEm;
    selectDut(2'd2);
    resetDut();
    startFraming();
    nAcc = 0; nEm = 0; oRdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      vld = (c < 10);
      inI = 16'($urandom);
      inQ = 16'h7FFF;
      if (obsValid) begin
        checks++;
        if (sent.size() == 0 || obsI !== sent[0] || obsSoP !== 1'b1 || obsEoP !== 1'b1 || obsQ !== 16'h0)
          $display("FAIL len1_out: got I=%h Q=%h sop=%b eop=%b required sop=eop=1 Q=0", obsI, obsQ, obsSoP, obsEoP);
        else passes++;
        if (sent.size() > 0) void'(sent.pop_front());
        nEm++;
      end
      if (vld && obsReady) begin
        sent.push_back(inI);
        nAcc++;
      end
      tick();
      checks++;
      if (obsFc !== nAcc[15:0]) $display("FAIL len1_frames: got %0d required %0d", obsFc, nAcc);
      else passes++;
    end
    checks++;
    if (nEm != 10) $display("FAIL len1_count: got %0d outputs required 10", nEm);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int nIn;
    bit done;
    selectDut(2'd1);
    resetDut();
    startFraming();
    nIn = 0; done = 0; oRdy = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      vld = 1'b1;
      inI = nIn[15:0];
      if (obsValid && obsI == 16'd13) begin
        done = 1;
      end else begin
        if (obsReady) nIn++;
        tick();
      end
    end
    checks++;
    if (!done || obsFc !== 16'd1) $display("FAIL rmid_reach: got reached=%b fc=%0d required 1 1", done, obsFc);
    else passes++;
    rstN = 1'b0;
    #1;
    checks++;
    if (obsValid !== 1'b0 || obsFc !== 16'd0 || obsBusy !== 1'b0)
      $display("FAIL rmid_async: got valid=%b fc=%0d busy=%b required 0 0 0", obsValid, obsFc, obsBusy);
    else passes++;
    @(negedge clk);
    en = 1'b0;
    clearModel();
    rstN = 1'b1;
    for (int c = 0; c < 5; c++) begin
      vld = 1'b1;
      inI = 16'(200 + c);
      tick();
      checks++;
      if (obsValid !== 1'b0) $display("FAIL rmid_idle: got valid=%b required 0", obsValid);
      else passes++;
    end
    startFraming();
    vld = 1'b1;
    inI = 16'd100;
    tick();
    vld = 1'b0;
    checks++;
    if (obsValid !== 1'b1 || obsI !== 16'd100 || obsSoP !== 1'b1)
      $display("FAIL rmid_restart: got valid=%b I=%0d sop=%b required 1 100 1", obsValid, obsI, obsSoP);
    else passes++;
  endtask

  task automatic test_random();
    bit     prevHeld;
    sampleT snap;
    sampleT e;
    int     cyc;
    selectDut(2'd3);
    resetDut();
    startFraming();
    prevHeld = 0; snap = '0; cyc = 0;
    while ((mFrames < 1000 || expQ.size() > 0) && cyc < 60000) begin
      vld  = (mFrames < 1000) && ($urandom_range(0, 1) == 1);
      inI  = 16'($urandom);
      inQ  = 16'($urandom);
      oRdy = 1'($urandom_range(0, 1));
      checks++;
      if (obsReady !== (expQ.size() < 2))
        $display("FAIL rnd_ready: got %b required %b (held %0d)", obsReady, (expQ.size() < 2), expQ.size());
      else passes++;
      checks++;
      if (obsValid !== (expQ.size() > 0))
        $display("FAIL rnd_valid: got %b required %b", obsValid, (expQ.size() > 0));
      else passes++;
      if (prevHeld) begin
        checks++;
        if ({obsI, obsQ, obsSoP, obsEoP} !== snap)
          $display("FAIL rnd_hold: got I=%h required I=%h", obsI, snap.i);
        else passes++;
      end
      if (obsValid && oRdy && expQ.size() > 0) begin
        e = expQ[0];
        checks++;
        if ({obsI, obsQ, obsSoP, obsEoP} !== e)
          $display("FAIL rnd_data: got I=%h Q=%h sop=%b eop=%b required I=%h Q=%h sop=%b eop=%b",
                   obsI, obsQ, obsSoP, obsEoP, e.i, e.q, e.sop, e.eop);
        else passes++;
      end
      prevHeld = obsValid && !oRdy;
      snap     = {obsI, obsQ, obsSoP, obsEoP};
      tick();
      cyc++;
    end
    checks++;
    if (cyc >= 60000) $display("FAIL rnd_timeout: got %0d frames after %0d cycles required 1000", mFrames, cyc);
    else passes++;
    checks++;
    if (obsFc !== 16'd1000) $display("FAIL rnd_frames: got %0d required 1000", obsFc);
    else passes++;
  endtask

  initial begin
    rstN = 1'b0; en = 1'b0; vld = 1'b0; oRdy = 1'b0; inI = '0; inQ = '0; sel = 2'd0;
    mLen = 4; mCplx = 1;
    clearModel();
    test_reset();
    test_basic();
    test_stall();
    test_enable_drop();
    test_length1();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
